bomb_scheduler: RTL and testbench

Owns the bomb slots shared by both players. It arbitrates placement requests and ages each bomb through new → armed → exploding → cleared on a 1 s tick. It publishes a frame-stable snapshot of slot state that the vga640x480 datapath decodes into its Bomb colour codes (datapath colour = stage + 3). It sits between the player/move logic and the VGA pixel path, in the pixel_clk domain.

---
 rtl/bomb_scheduler_if.sv | 35 +++
 rtl/bomb_scheduler.sv | 146 ++++++++++++++
 tb/tb_bomb_scheduler.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bomb_scheduler_if.sv
// bomb_scheduler_if: placement handshakes, halt/frame strobes and the display snapshot bus
// shared between the player logic, the bomb scheduler and the VGA datapath.
interface bomb_scheduler_if #(
    parameter int SLOTS = 4
);
    logic               frame_start;
    logic               halt;
    logic               p1_req;
    logic [3:0]         p1_x;
    logic [3:0]         p1_y;
    logic               p2_req;
    logic [3:0]         p2_x;
    logic [3:0]         p2_y;
    logic               p1_ack;
    logic               p1_nack;
    logic               p2_ack;
    logic               p2_nack;
    logic [SLOTS-1:0]   disp_valid;
    logic [4*SLOTS-1:0] disp_x;
    logic [4*SLOTS-1:0] disp_y;
    logic [2*SLOTS-1:0] disp_stage;
    logic [SLOTS-1:0]   blast_pulse;

    modport master (
        output frame_start, halt, p1_req, p1_x, p1_y, p2_req, p2_x, p2_y,
        input  p1_ack, p1_nack, p2_ack, p2_nack,
        input  disp_valid, disp_x, disp_y, disp_stage, blast_pulse
    );

    modport slave (
        input  frame_start, halt, p1_req, p1_x, p1_y, p2_req, p2_x, p2_y,
        output p1_ack, p1_nack, p2_ack, p2_nack,
        output disp_valid, disp_x, disp_y, disp_stage, blast_pulse
    );
endinterface

// File: rtl/bomb_scheduler.sv
// bomb_scheduler: arbitrates two players' bomb placements and ages slots new->armed->exploding on a tick.
// Define BOMB_LIMIT_EN to track slot owners and cap each player at one live bomb.
module bomb_scheduler #(
    parameter int SLOTS    = 4,
    parameter int TICK_DIV = 25000000,
    parameter int GRID     = 10
) (
    input logic             pixel_clk,
    input logic             rst,
    bomb_scheduler_if.slave bus
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        NEW     = 2'd1,
        ARMED   = 2'd2,
        EXPLODE = 2'd3
    } stage_t;

    stage_t             stage_q [SLOTS];
    stage_t             stage_d [SLOTS];
    logic [3:0]         x_q [SLOTS];
    logic [3:0]         x_d [SLOTS];
    logic [3:0]         y_q [SLOTS];
    logic [3:0]         y_d [SLOTS];
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               rr_q, rr_d;
    logic               p1_ack_q, p1_nack_q, p2_ack_q, p2_nack_q;
    logic               p1_ack_d, p1_nack_d, p2_ack_d, p2_nack_d;
    logic [SLOTS-1:0]   blast_q, blast_d;
    logic [SLOTS-1:0]   valid_q;
    logic [4*SLOTS-1:0] disp_x_q, disp_y_q;
    logic [2*SLOTS-1:0] disp_stage_q;
    logic               tick, serve, serve_p2, hit, owned, any_free, accept;
    logic [3:0]         rx, ry;
    logic [SW-1:0]      sel;
`ifdef BOMB_LIMIT_EN
    logic               owner_q [SLOTS];
    logic               owner_d [SLOTS];
`endif

    always_comb begin
        tick     = !bus.halt && cnt_q == CW'(TICK_DIV - 1);
        cnt_d    = bus.halt ? cnt_q : tick ? '0 : cnt_q + 1'b1;
        serve    = bus.p1_req || bus.p2_req;
        serve_p2 = bus.p2_req && (!bus.p1_req || rr_q);
        rr_d     = bus.p1_req && bus.p2_req ? !rr_q : rr_q;
        rx       = serve_p2 ? bus.p2_x : bus.p1_x;
        ry       = serve_p2 ? bus.p2_y : bus.p1_y;
        hit      = 1'b0;
        owned    = 1'b0;
        any_free = 1'b0;
        sel      = '0;
        // Descending scan so the lowest idle index is the one left in sel.
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (stage_q[i] == IDLE) begin
                any_free = 1'b1;
                sel      = SW'(i);
            end else begin
                hit = hit || (x_q[i] == rx && y_q[i] == ry);
`ifdef BOMB_LIMIT_EN
                owned = owned || owner_q[i] == serve_p2;
`endif
            end
        end
        accept = serve && !bus.halt && int'(rx) < GRID && int'(ry) < GRID && !hit && !owned && any_free;
        for (int i = 0; i < SLOTS; i++) begin
            stage_d[i] = tick && stage_q[i] != IDLE ? stage_t'(stage_q[i] + 2'd1) : stage_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            blast_d[i] = tick && stage_q[i] == ARMED;
`ifdef BOMB_LIMIT_EN
            owner_d[i] = owner_q[i];
`endif
        end
        // The allocated slot was idle, so overriding its tick advance costs nothing.
        if (accept) begin
            stage_d[sel] = NEW;
            x_d[sel]     = rx;
            y_d[sel]     = ry;
`ifdef BOMB_LIMIT_EN
            owner_d[sel] = serve_p2;
`endif
        end
        p1_ack_d  = serve && !serve_p2 && accept;
        p1_nack_d = serve && !serve_p2 && !accept;
        p2_ack_d  = serve_p2 && accept;
        p2_nack_d = serve_p2 && !accept;
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            stage_q      <= '{default: IDLE};
            x_q          <= '{default: '0};
            y_q          <= '{default: '0};
            cnt_q        <= '0;
            rr_q         <= 1'b0;
            p1_ack_q     <= 1'b0;
            p1_nack_q    <= 1'b0;
            p2_ack_q     <= 1'b0;
            p2_nack_q    <= 1'b0;
            blast_q      <= '0;
            valid_q      <= '0;
            disp_x_q     <= '0;
            disp_y_q     <= '0;
            disp_stage_q <= '0;
`ifdef BOMB_LIMIT_EN
            owner_q      <= '{default: 1'b0};
`endif
        end else begin
            stage_q   <= stage_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            p1_ack_q  <= p1_ack_d;
            p1_nack_q <= p1_nack_d;
            p2_ack_q  <= p2_ack_d;
            p2_nack_q <= p2_nack_d;
            blast_q   <= blast_d;
`ifdef BOMB_LIMIT_EN
            owner_q   <= owner_d;
`endif
            if (bus.frame_start) begin
                for (int i = 0; i < SLOTS; i++) begin
                    valid_q[i]             <= stage_q[i] != IDLE;
                    disp_x_q[4*i +: 4]     <= stage_q[i] != IDLE ? x_q[i] : 4'd0;
                    disp_y_q[4*i +: 4]     <= stage_q[i] != IDLE ? y_q[i] : 4'd0;
                    disp_stage_q[2*i +: 2] <= stage_q[i];
                end
            end
        end
    end

    assign bus.p1_ack      = p1_ack_q;
    assign bus.p1_nack     = p1_nack_q;
    assign bus.p2_ack      = p2_ack_q;
    assign bus.p2_nack     = p2_nack_q;
    assign bus.blast_pulse = blast_q;
    assign bus.disp_valid  = valid_q;
    assign bus.disp_x      = disp_x_q;
    assign bus.disp_y      = disp_y_q;
    assign bus.disp_stage  = disp_stage_q;
endmodule

// File: tb/tb_bomb_scheduler.sv
// tb_bomb_scheduler: directed and random placements scored against a model that derives each
// bomb's stage from the number of ticks elapsed since it was placed.
`timescale 1ns/1ps
module tb_bomb_scheduler;
    localparam int SLOTS    = 4;
    localparam int TICK_DIV = 8;
    localparam int GRID     = 10;

    typedef struct {
        int unsigned      cyc;
        logic [SLOTS-1:0] v;
    } exp_t;

    typedef struct packed {
        logic [SLOTS-1:0]   valid;
        logic [4*SLOTS-1:0] x;
        logic [4*SLOTS-1:0] y;
        logic [2*SLOTS-1:0] st;
    } snap_t;

    logic pixel_clk = 1'b0;
    logic rst = 1'b1;

    bomb_scheduler_if #(.SLOTS(SLOTS)) bus ();

    bomb_scheduler #(.SLOTS(SLOTS), .TICK_DIV(TICK_DIV), .GRID(GRID)) dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 pixel_clk = ~pixel_clk;

    int          passed = 0;
    int          total  = 0;
    int unsigned cyc    = 0;
    int unsigned run    = 0;
    int unsigned ticks  = 0;
    bit          rr     = 1'b0;
    bit          mv [SLOTS];
    bit          mo [SLOTS];
    int unsigned mt [SLOTS];
    logic [3:0]  mx [SLOTS];
    logic [3:0]  my [SLOTS];
    exp_t        p1q[$], p2q[$], blq[$];
    snap_t       snq[$];
    snap_t       held = '0;

    bit               m_tick, m_who, m_ok;
    int               m_fr;
    logic [3:0]       m_x, m_y;
    logic [SLOTS-1:0] m_b;
    snap_t            m_s;
    exp_t             mr;
    logic [SLOTS-1:0] e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_acks"}, {bus.p1_ack, bus.p1_nack, bus.p2_ack, bus.p2_nack}, 0);
        chk({tag, "_disp_valid"}, bus.disp_valid, 0);
        chk({tag, "_disp_x"}, bus.disp_x, 0);
        chk({tag, "_disp_y"}, bus.disp_y, 0);
        chk({tag, "_disp_stage"}, bus.disp_stage, 0);
        chk({tag, "_blast"}, bus.blast_pulse, 0);
    endtask

    // Stage of a bomb = 1 + ticks elapsed since placement; three ticks later it is gone.
    function automatic int stg(int i);
        return (mv[i] && ticks - mt[i] <= 2) ? 1 + int'(ticks - mt[i]) : 0;
    endfunction

    always @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            run   = 0;
            ticks = 0;
            rr    = 1'b0;
            foreach (mv[i]) mv[i] = 1'b0;
            p1q.delete();
            p2q.delete();
            blq.delete();
            snq.delete();
        end else begin
            cyc++;
            m_tick = !bus.halt && (run % TICK_DIV) == TICK_DIV - 1;
            m_b    = '0;
            m_s    = '0;
            for (int i = 0; i < SLOTS; i++) begin
                m_b[i] = m_tick && stg(i) == 2;
                if (stg(i) != 0) begin
                    m_s.valid[i]     = 1'b1;
                    m_s.x[4*i +: 4]  = mx[i];
                    m_s.y[4*i +: 4]  = my[i];
                end
                m_s.st[2*i +: 2] = 2'(stg(i));
            end
            if (m_b != 0) blq.push_back('{cyc, m_b});
            if (bus.frame_start) snq.push_back(m_s);
            if (bus.p1_req || bus.p2_req) begin
                m_who = bus.p2_req && (!bus.p1_req || rr);
                if (bus.p1_req && bus.p2_req) rr = !rr;
                m_x  = m_who ? bus.p2_x : bus.p1_x;
                m_y  = m_who ? bus.p2_y : bus.p1_y;
                m_ok = !bus.halt && m_x < GRID && m_y < GRID;
                m_fr = -1;
                for (int i = 0; i < SLOTS; i++) begin
                    if (stg(i) != 0) begin
                        if (mx[i] == m_x && my[i] == m_y) m_ok = 1'b0;
`ifdef BOMB_LIMIT_EN
                        if (mo[i] == m_who) m_ok = 1'b0;
`endif
                    end else if (m_fr < 0) m_fr = i;
                end
                if (m_fr < 0) m_ok = 1'b0;
                if (m_ok) begin
                    mv[m_fr] = 1'b1;
                    mx[m_fr] = m_x;
                    my[m_fr] = m_y;
                    mo[m_fr] = m_who;
                    mt[m_fr] = ticks + (m_tick ? 1 : 0);
                end
                if (m_who) p2q.push_back('{cyc, SLOTS'(m_ok ? 2 : 1)});
                else p1q.push_back('{cyc, SLOTS'(m_ok ? 2 : 1)});
            end
            ticks += m_tick ? 1 : 0;
            run   += bus.halt ? 0 : 1;
        end
    end

    always @(negedge pixel_clk) begin
        if (rst) held = '0;
        else begin
            if (snq.size() > 0) held = snq.pop_front();
            chk("disp_valid", bus.disp_valid, held.valid);
            chk("disp_x", bus.disp_x, held.x);
            chk("disp_y", bus.disp_y, held.y);
            chk("disp_stage", bus.disp_stage, held.st);
            e = '0;
            if (p1q.size() > 0 && p1q[0].cyc == cyc) begin mr = p1q.pop_front(); e = mr.v; end
            chk("p1_result", {bus.p1_ack, bus.p1_nack}, e);
            e = '0;
            if (p2q.size() > 0 && p2q[0].cyc == cyc) begin mr = p2q.pop_front(); e = mr.v; end
            chk("p2_result", {bus.p2_ack, bus.p2_nack}, e);
            e = '0;
            if (blq.size() > 0 && blq[0].cyc == cyc) begin mr = blq.pop_front(); e = mr.v; end
            chk("blast_pulse", bus.blast_pulse, e);
        end
    end

    initial begin
        bus.frame_start = 1'b0;
        forever begin
            @(negedge pixel_clk);
            bus.frame_start = $urandom_range(0, 4) == 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge pixel_clk);
    endtask

    // Called at a negedge; each requester drops req as soon as its result pulse shows.
    task automatic place(input bit a, input logic [3:0] ax, input logic [3:0] ay,
                         input bit b, input logic [3:0] bx, input logic [3:0] by);
        bus.p1_req = a;
        bus.p1_x   = ax;
        bus.p1_y   = ay;
        bus.p2_req = b;
        bus.p2_x   = bx;
        bus.p2_y   = by;
        for (int n = 0; n < 8 && (bus.p1_req || bus.p2_req); n++) begin
            @(negedge pixel_clk);
            if (bus.p1_ack || bus.p1_nack) bus.p1_req = 1'b0;
            if (bus.p2_ack || bus.p2_nack) bus.p2_req = 1'b0;
        end
        chk("place_done", {bus.p1_req, bus.p2_req}, 0);
        bus.p1_req = 1'b0;
        bus.p2_req = 1'b0;
    endtask

    initial begin
        bus.halt   = 1'b0;
        bus.p1_req = 1'b0;
        bus.p2_req = 1'b0;
        bus.p1_x   = '0;
        bus.p1_y   = '0;
        bus.p2_x   = '0;
        bus.p2_y   = '0;
        repeat (3) @(negedge pixel_clk);
        chk_zero("reset");
        rst = 1'b0;
        place(1, 3, 4, 0, 0, 0);
        idle(30);
        place(1, 2, 2, 1, 5, 5);
        place(1, 7, 7, 1, 7, 7);
        idle(30);
        place(1, 10, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) place(1, 4'(i), 4'(i + 1), 0, 0, 0);
        place(0, 0, 0, 1, 9, 9);
        bus.halt = 1'b1;
        place(1, 8, 8, 0, 0, 0);
        idle(20);
        bus.halt = 1'b0;
        idle(30);
        for (int n = 0; n < 16 && (run % TICK_DIV) != TICK_DIV - 1; n++) @(negedge pixel_clk);
        place(1, 6, 6, 0, 0, 0);
        idle(30);
        for (int k = 0; k < 60; k++) begin
            bus.halt = $urandom_range(0, 9) == 0;
            place(1'($urandom_range(0, 1)), 4'($urandom_range(0, 10)), 4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 10)), 4'($urandom_range(0, 3)));
            bus.halt = 1'b0;
            idle($urandom_range(0, 4));
        end
        idle(30);
        place(1, 1, 1, 0, 0, 0);
        idle(9);
        place(0, 0, 0, 1, 2, 3);
        idle(6);
        #2 rst = 1'b1;
        #1 chk_zero("async_reset");
        repeat (2) @(negedge pixel_clk);
        rst = 1'b0;
        idle(3);
        place(1, 1, 1, 0, 0, 0);
        place(1, 2, 2, 0, 0, 0);
        place(0, 0, 0, 1, 3, 3);
        idle(30);
        chk("p1q_drained", p1q.size(), 0);
        chk("p2q_drained", p2q.size(), 0);
        chk("blast_drained", blq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run exceeded its time limit (%0d/%0d)", passed, total);
        $fatal(1, "watchdog expired");
    end
endmodule
